// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute/writeback sequencer
// that feeds decoded ARM fields and the NZCV register to the ALU.
module control_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        cu_execute,
    output logic [4:0]  instrution,
    output logic [3:0]  rn_sel,
    output logic [3:0]  rm_sel,
    output logic [3:0]  rs_sel,
    output logic [3:0]  rd_sel,
    output logic [4:0]  imm_shift,
    output logic [11:0] imm_operand,
    output logic [23:0] br_offset_imm,
    output logic        br_L,
    output logic        IMM,
    output logic        S,
    output logic [1:0]  stype,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flag_v,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v,
    input  logic [31:0] alu_rd,
    input  logic [31:0] alu_w_pc,
    input  logic [31:0] alu_w_lr,
    output logic [31:0] pc,
    output logic        rf_we,
    output logic        lr_we,
    output logic        undef
);

    localparam logic [4:0] OP_MOV_LAS = 5'h0D;
    localparam logic [4:0] OP_B       = 5'h10;
    localparam logic [4:0] OP_BX      = 5'h11;
    localparam logic [4:0] OP_ERET    = 5'h12;
    localparam logic [4:0] OP_UNDEF   = 5'h1F;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    state_t      r_state;
    logic [31:0] r_ir;
    logic [31:0] r_pc;
    logic        r_n, r_z, r_c, r_v;
    logic        r_req;
    logic        r_exec;
    logic        r_cu_execute;
    logic [4:0]  r_op;
    logic [3:0]  r_rn, r_rm, r_rs, r_rd;
    logic [4:0]  r_sh;
    logic [11:0] r_imm;
    logic [23:0] r_off;
    logic        r_brl, r_immb, r_s;
    logic [1:0]  r_st;
    logic        r_rf_we, r_lr_we, r_undef;

    logic        w_is_b, w_is_bx, w_is_eret, w_is_mov;
    logic [4:0]  w_op;
    logic        w_cond;
    logic        w_unused;

    // Link value and ALU V are consumed elsewhere, never by the sequencer.
    assign w_unused = ^{alu_w_lr, alu_v};

    assign w_is_b    = (r_ir[27:25] == 3'b101);
    assign w_is_bx   = (r_ir[27:4] == 24'h12FFF1);
    assign w_is_eret = (r_ir[27:0] == 28'h160006E);
    assign w_is_mov  = (r_ir[27:26] == 2'b00) &&
                       (r_ir[24:21] == 4'b1101);

    always_comb begin
        w_op = OP_UNDEF;
        unique case (1'b1)
            w_is_b:    w_op = OP_B;
            w_is_bx:   w_op = OP_BX;
            w_is_eret: w_op = OP_ERET;
            w_is_mov:  w_op = OP_MOV_LAS;
            default:   w_op = OP_UNDEF;
        endcase
    end

    always_comb begin
        w_cond = 1'b0;
        unique case (r_ir[31:28])
            4'h0: w_cond = r_z;
            4'h1: w_cond = !r_z;
            4'h2: w_cond = r_c;
            4'h3: w_cond = !r_c;
            4'h4: w_cond = r_n;
            4'h5: w_cond = !r_n;
            4'h6: w_cond = r_v;
            4'h7: w_cond = !r_v;
            4'h8: w_cond = r_c && !r_z;
            4'h9: w_cond = !r_c || r_z;
            4'hA: w_cond = (r_n == r_v);
            4'hB: w_cond = (r_n != r_v);
            4'hC: w_cond = !r_z && (r_n == r_v);
            4'hD: w_cond = r_z || (r_n != r_v);
            4'hE: w_cond = 1'b1;
            4'hF: w_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_FETCH;
            r_ir         <= '0;
            r_pc         <= RESET_PC;
            r_n          <= 1'b0;
            r_z          <= 1'b0;
            r_c          <= 1'b0;
            r_v          <= 1'b0;
            r_req        <= 1'b0;
            r_exec       <= 1'b0;
            r_cu_execute <= 1'b0;
            r_op         <= OP_UNDEF;
            r_rn         <= '0;
            r_rm         <= '0;
            r_rs         <= '0;
            r_rd         <= '0;
            r_sh         <= '0;
            r_imm        <= '0;
            r_off        <= '0;
            r_brl        <= 1'b0;
            r_immb       <= 1'b0;
            r_s          <= 1'b0;
            r_st         <= '0;
            r_rf_we      <= 1'b0;
            r_lr_we      <= 1'b0;
            r_undef      <= 1'b0;
        end else begin
            r_cu_execute <= 1'b0;
            r_rf_we      <= 1'b0;
            r_lr_we      <= 1'b0;
            r_undef      <= 1'b0;
            unique case (r_state)
                S_FETCH: begin
                    r_req <= 1'b1;
                    if (r_req && imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_req   <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_op         <= w_op;
                    r_exec       <= w_cond && (w_op != OP_UNDEF);
                    r_cu_execute <= w_cond && (w_op != OP_UNDEF);
                    r_rn   <= '0;
                    r_rm   <= '0;
                    r_rs   <= '0;
                    r_rd   <= '0;
                    r_sh   <= '0;
                    r_imm  <= '0;
                    r_off  <= '0;
                    r_brl  <= 1'b0;
                    r_immb <= 1'b0;
                    r_s    <= 1'b0;
                    r_st   <= '0;
                    if (w_is_b) begin
                        r_brl <= r_ir[24];
                        r_off <= r_ir[23:0];
                    end
                    if (w_is_bx) begin
                        r_rm <= r_ir[3:0];
                    end
                    if (w_is_mov) begin
                        r_immb <= r_ir[25];
                        r_s    <= r_ir[20];
                        r_rn   <= r_ir[19:16];
                        r_rd   <= r_ir[15:12];
                        r_rs   <= r_ir[11:8];
                        r_sh   <= r_ir[11:7];
                        r_st   <= r_ir[6:5];
                        r_rm   <= r_ir[3:0];
                        r_imm  <= r_ir[11:0];
                    end
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    r_undef <= (r_op == OP_UNDEF);
                    if (r_exec && r_op == OP_MOV_LAS) begin
                        r_rf_we <= 1'b1;
                        r_pc    <= r_pc + 32'd4;
                        if (r_s) begin
                            r_n <= alu_n;
                            r_z <= alu_z;
                            r_c <= alu_c;
                        end
                    end else if (r_exec && r_op == OP_B) begin
                        r_pc    <= alu_w_pc;
                        r_lr_we <= r_brl;
                    end else if (r_exec && r_op == OP_BX) begin
                        r_pc    <= alu_rd & ~32'h1;
                        r_lr_we <= r_brl;
                    end else begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem_req      = r_req;
    assign imem_addr     = r_pc;
    assign pc            = r_pc;
    assign cu_execute    = r_cu_execute;
    assign instrution    = r_op;
    assign rn_sel        = r_rn;
    assign rm_sel        = r_rm;
    assign rs_sel        = r_rs;
    assign rd_sel        = r_rd;
    assign imm_shift     = r_sh;
    assign imm_operand   = r_imm;
    assign br_offset_imm = r_off;
    assign br_L          = r_brl;
    assign IMM           = r_immb;
    assign S             = r_s;
    assign stype         = r_st;
    assign flag_n        = r_n;
    assign flag_z        = r_z;
    assign flag_c        = r_c;
    assign flag_v        = r_v;
    assign rf_we         = r_rf_we;
    assign lr_we         = r_lr_we;
    assign undef         = r_undef;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, reset corner case,
// then random instructions against an ARM-rule reference model.
module tb_control_unit;

    localparam logic [4:0] OP_MOV   = 5'h0D;
    localparam logic [4:0] OP_B     = 5'h10;
    localparam logic [4:0] OP_BX    = 5'h11;
    localparam logic [4:0] OP_ERET  = 5'h12;
    localparam logic [4:0] OP_UNDEF = 5'h1F;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        cu_execute;
    logic [4:0]  instrution;
    logic [3:0]  rn_sel, rm_sel, rs_sel, rd_sel;
    logic [4:0]  imm_shift;
    logic [11:0] imm_operand;
    logic [23:0] br_offset_imm;
    logic        br_L, IMM, S;
    logic [1:0]  stype;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic [3:0]  anzcv;
    logic [31:0] alu_rd, alu_w_pc, alu_w_lr;
    logic [31:0] pc;
    logic        rf_we, lr_we, undef;

    int n_chk = 0;
    int n_fail = 0;

    control_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .cu_execute(cu_execute), .instrution(instrution),
        .rn_sel(rn_sel), .rm_sel(rm_sel),
        .rs_sel(rs_sel), .rd_sel(rd_sel),
        .imm_shift(imm_shift), .imm_operand(imm_operand),
        .br_offset_imm(br_offset_imm), .br_L(br_L),
        .IMM(IMM), .S(S), .stype(stype),
        .flag_n(flag_n), .flag_z(flag_z),
        .flag_c(flag_c), .flag_v(flag_v),
        .alu_n(anzcv[3]), .alu_z(anzcv[2]),
        .alu_c(anzcv[1]), .alu_v(anzcv[0]),
        .alu_rd(alu_rd), .alu_w_pc(alu_w_pc), .alu_w_lr(alu_w_lr),
        .pc(pc), .rf_we(rf_we), .lr_we(lr_we), .undef(undef)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          req_cnt;
        logic        req_after;
        int          exec_cnt;
        logic        exec_at;
        logic [4:0]  op;
        logic [3:0]  rd, rm, rs;
        logic [4:0]  sh;
        logic [1:0]  st;
        logic [11:0] imm;
        logic        immb, s, brl;
        logic [23:0] off;
        logic        rf, lr, und;
        logic [31:0] pc;
        logic [3:0]  nzcv;
        logic        timeout;
    } obs_t;

    typedef struct {
        logic [31:0] ir;
        int          waits;
        logic [31:0] rd, wpc, wlr;
        logic [3:0]  an;
        logic [4:0]  op;
        logic        ex, rf, lr, un;
        logic [31:0] pc;
        logic [3:0]  nz;
        logic [3:0]  rm, rdi;
        logic        brl;
        logic [23:0] off;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic noise(input bit en);
        if (en) begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
        end else begin
            imem_ack = 1'b0;
        end
    endtask

    task automatic do_instr(input logic [31:0] ir, input int waits,
                            input bit nz, output obs_t o);
        int g;
        g = 0;
        o = '{default: 0};
        while (imem_req !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (imem_req !== 1'b1) begin
            o.timeout = 1'b1;
            return;
        end
        imem_rdata = ir;
        for (int k = 0; k < waits; k++) begin
            imem_ack = 1'b0;
            o.req_cnt += int'(imem_req);
            @(negedge clk);
        end
        imem_ack = 1'b1;
        o.req_cnt += int'(imem_req);
        o.addr = imem_addr;
        @(negedge clk);
        o.req_after = imem_req;
        o.exec_cnt += int'(cu_execute);
        noise(nz);
        @(negedge clk);
        o.exec_at = cu_execute;
        o.exec_cnt += int'(cu_execute);
        noise(nz);
        @(negedge clk);
        o.exec_cnt += int'(cu_execute);
        o.op   = instrution;
        o.rd   = rd_sel;
        o.rm   = rm_sel;
        o.rs   = rs_sel;
        o.sh   = imm_shift;
        o.st   = stype;
        o.imm  = imm_operand;
        o.immb = IMM;
        o.s    = S;
        o.brl  = br_L;
        o.off  = br_offset_imm;
        noise(nz);
        @(negedge clk);
        imem_ack = 1'b0;
        o.exec_cnt += int'(cu_execute);
        o.rf   = rf_we;
        o.lr   = lr_we;
        o.und  = undef;
        o.pc   = pc;
        o.nzcv = {flag_n, flag_z, flag_c, flag_v};
    endtask

    function automatic logic cond_ok(input logic [3:0] c,
                                     input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        base = 1'b1;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        if (c == 4'hE) return 1'b1;
        return c[0] ? !base : base;
    endfunction

    function automatic logic [4:0] classify(input logic [31:0] ir);
        if (ir[27:25] == 3'b101) return OP_B;
        if (ir[27:4] == 24'h12FFF1) return OP_BX;
        if (ir[27:0] == 28'h160006E) return OP_ERET;
        if (ir[27:26] == 2'b00 && ir[24:21] == 4'b1101)
            return OP_MOV;
        return OP_UNDEF;
    endfunction

    vec_t tv[12];
    obs_t o;

    initial begin
        logic [31:0] m_pc, ir, r, e_pc;
        logic [3:0]  m_f, cnd;
        logic [4:0]  e_op;
        logic        ok, e_rf, e_lr;
        int          k, g, w;

        rst = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        anzcv = '0;
        alu_rd = '0;
        alu_w_pc = '0;
        alu_w_lr = '0;

        tv[0]  = '{32'hE1B00001, 0, 32'h0, 32'h0, 32'h0, 4'b0101,
                   OP_MOV, 1, 1, 0, 0, 32'h4, 4'b0100,
                   4'd1, 4'd0, 0, 24'h0};
        tv[1]  = '{32'hE1B02003, 1, 32'h7, 32'h0, 32'h0, 4'b0010,
                   OP_MOV, 1, 1, 0, 0, 32'h8, 4'b0010,
                   4'd3, 4'd2, 0, 24'h0};
        tv[2]  = '{32'h01A00001, 0, 32'h5, 32'h0, 32'h0, 4'b1111,
                   OP_MOV, 0, 0, 0, 0, 32'hC, 4'b0010,
                   4'd1, 4'd0, 0, 24'h0};
        tv[3]  = '{32'hEB000010, 0, 32'h0, 32'h48, 32'h4, 4'b0000,
                   OP_B, 1, 0, 1, 0, 32'h48, 4'b0010,
                   4'd0, 4'd0, 1, 24'h10};
        tv[4]  = '{32'hE12FFF13, 2, 32'h101, 32'h0, 32'h0, 4'b0000,
                   OP_BX, 1, 0, 0, 0, 32'h100, 4'b0010,
                   4'd3, 4'd0, 0, 24'h0};
        tv[5]  = '{32'hE7F000F0, 3, 32'h0, 32'h0, 32'h0, 4'b0000,
                   OP_UNDEF, 0, 0, 0, 1, 32'h104, 4'b0010,
                   4'd0, 4'd0, 0, 24'h0};
        tv[6]  = '{32'hE160006E, 0, 32'h0, 32'h800, 32'h0, 4'b0000,
                   OP_ERET, 1, 0, 0, 0, 32'h108, 4'b0010,
                   4'd0, 4'd0, 0, 24'h0};
        tv[7]  = '{32'hF1B00001, 0, 32'h0, 32'h0, 32'h0, 4'b1111,
                   OP_MOV, 0, 0, 0, 0, 32'h10C, 4'b0010,
                   4'd1, 4'd0, 0, 24'h0};
        tv[8]  = '{32'hEA000000, 0, 32'h0, 32'hFFFFFFFC, 32'h0, 4'b0,
                   OP_B, 1, 0, 0, 0, 32'hFFFFFFFC, 4'b0010,
                   4'd0, 4'd0, 0, 24'h0};
        tv[9]  = '{32'hE1A00004, 1, 32'h0, 32'h0, 32'h0, 4'b1101,
                   OP_MOV, 1, 1, 0, 0, 32'h0, 4'b0010,
                   4'd4, 4'd0, 0, 24'h0};
        tv[10] = '{32'h21B00000, 0, 32'h0, 32'h0, 32'h0, 4'b1001,
                   OP_MOV, 1, 1, 0, 0, 32'h4, 4'b1000,
                   4'd0, 4'd0, 0, 24'h0};
        tv[11] = '{32'h4A000003, 0, 32'h0, 32'h200, 32'h0, 4'b0000,
                   OP_B, 1, 0, 0, 0, 32'h200, 4'b1000,
                   4'd0, 4'd0, 0, 24'h3};

        repeat (2) @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_exec", cu_execute, 0);
        chk("rst_op", instrution, OP_UNDEF);
        chk("rst_pc", pc, 32'h0);
        chk("rst_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
        chk("rst_strobes", {rf_we, lr_we, undef}, 0);
        chk("rst_fields", {rd_sel, rm_sel, br_L, br_offset_imm}, 0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            alu_rd   = tv[i].rd;
            alu_w_pc = tv[i].wpc;
            alu_w_lr = tv[i].wlr;
            anzcv    = tv[i].an;
            do_instr(tv[i].ir, tv[i].waits, 1'b0, o);
            chk($sformatf("v%0d_timeout", i), o.timeout, 0);
            chk($sformatf("v%0d_req", i), o.req_cnt, tv[i].waits + 1);
            chk($sformatf("v%0d_reqdrop", i), o.req_after, 0);
            chk($sformatf("v%0d_op", i), o.op, tv[i].op);
            chk($sformatf("v%0d_exec", i), o.exec_cnt, tv[i].ex);
            chk($sformatf("v%0d_exec_at", i), o.exec_at, tv[i].ex);
            chk($sformatf("v%0d_rf", i), o.rf, tv[i].rf);
            chk($sformatf("v%0d_lr", i), o.lr, tv[i].lr);
            chk($sformatf("v%0d_undef", i), o.und, tv[i].un);
            chk($sformatf("v%0d_pc", i), o.pc, tv[i].pc);
            chk($sformatf("v%0d_nzcv", i), o.nzcv, tv[i].nz);
            if (tv[i].op == OP_MOV)
                chk($sformatf("v%0d_regs", i), {o.rm, o.rd},
                    {tv[i].rm, tv[i].rdi});
            if (tv[i].op == OP_BX)
                chk($sformatf("v%0d_rm", i), o.rm, tv[i].rm);
            if (tv[i].op == OP_B)
                chk($sformatf("v%0d_br", i), {o.brl, o.off},
                    {tv[i].brl, tv[i].off});
        end

        // Reset asserted while the BL is in EXECUTE.
        alu_w_pc = 32'h400;
        alu_w_lr = 32'h204;
        g = 0;
        while (imem_req !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("mid_fetch_req", imem_req, 1);
        imem_rdata = 32'hEB000010;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("mid_pre_exec", cu_execute, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_exec_drop", cu_execute, 0);
        chk("mid_pc", pc, 32'h0);
        chk("mid_req", imem_req, 0);
        chk("mid_op", instrution, OP_UNDEF);
        chk("mid_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_strobes", {rf_we, lr_we, undef, cu_execute}, 0);
        @(negedge clk);
        chk("mid_refetch_req", imem_req, 1);
        chk("mid_refetch_addr", imem_addr, 32'h0);

        m_pc = 32'h0;
        m_f  = 4'h0;
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 4);
            cnd = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) cnd = 4'hE;
            r = $urandom;
            case (k)
                0: ir = {cnd, 2'b00, r[25], 4'b1101, r[20:0]};
                1: ir = {cnd, 3'b101, r[24:0]};
                2: ir = {cnd, 24'h12FFF1, r[3:0]};
                3: ir = {cnd, 28'h160006E};
                default: ir = r;
            endcase
            w = $urandom_range(0, 3);
            alu_rd   = $urandom;
            alu_w_pc = $urandom;
            alu_w_lr = $urandom;
            anzcv    = 4'($urandom);

            e_op = classify(ir);
            ok   = cond_ok(ir[31:28], m_f) && (e_op != OP_UNDEF);
            e_pc = m_pc + 32'd4;
            e_rf = 1'b0;
            e_lr = 1'b0;
            if (ok && e_op == OP_MOV) begin
                e_rf = 1'b1;
                if (ir[20]) m_f[3:1] = anzcv[3:1];
            end
            if (ok && e_op == OP_B) begin
                e_pc = alu_w_pc;
                e_lr = ir[24];
            end
            if (ok && e_op == OP_BX) e_pc = alu_rd & ~32'h1;

            do_instr(ir, w, 1'b1, o);
            chk($sformatf("r%0d_timeout", i), o.timeout, 0);
            chk($sformatf("r%0d_addr", i), o.addr, m_pc);
            chk($sformatf("r%0d_req", i), o.req_cnt, w + 1);
            chk($sformatf("r%0d_op", i), o.op, e_op);
            chk($sformatf("r%0d_exec", i), o.exec_cnt, 32'(ok));
            chk($sformatf("r%0d_exec_at", i), o.exec_at, ok);
            chk($sformatf("r%0d_strb", i), {o.rf, o.lr, o.und},
                {e_rf, e_lr, e_op == OP_UNDEF});
            chk($sformatf("r%0d_pc", i), o.pc, e_pc);
            chk($sformatf("r%0d_nzcv", i), o.nzcv, m_f);
            if (e_op == OP_MOV) begin
                chk($sformatf("r%0d_mregs", i), {o.rd, o.rm, o.rs},
                    {ir[15:12], ir[3:0], ir[11:8]});
                chk($sformatf("r%0d_mimm", i),
                    {o.immb, o.s, o.sh, o.st, o.imm},
                    {ir[25], ir[20], ir[11:7], ir[6:5], ir[11:0]});
            end
            if (e_op == OP_B)
                chk($sformatf("r%0d_br", i), {o.brl, o.off},
                    {ir[24], ir[23:0]});
            if (e_op == OP_BX)
                chk($sformatf("r%0d_bx", i), o.rm, ir[3:0]);
            m_pc = e_pc;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
